spi_mem_bridge: RTL and testbench
=================================

# spi_mem_bridge

SPI mode-0 slave front-end that converts byte-serial SPI frames into single-cycle write and read strobes for the 16-byte DFF RAM stage directly downstream. It returns read data on MISO and auto-increments the address for bursts. All SPI inputs are oversampled in the system clock domain; no SPI clock is used as a clock.

## Interface
- `ADDR_W`, 4: RAM address width; addresses wrap modulo 2^ADDR_W.
- `SYNC_STAGES`, 2: synchronizer depth on `spi_cs_n`, `spi_sclk` and `spi_mosi`.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: when low, forces IDLE and deasserts all strobes.
- `spi_cs_n` in 1: frame select, active-low, asynchronous.
- `spi_sclk` in 1: SPI clock, asynchronous, idle low.
- `spi_mosi` in 1: serial data in, MSB first.
- `spi_miso` out 1: serial data out, MSB first.
- `spi_miso_oe` out 1: high while a read frame is in its data phase.
- `mem_addr` out ADDR_W: RAM address.
- `mem_ce_n` out 1: read strobe to the RAM, active-low, one cycle.
- `mem_lr_n` out 1: write strobe to the RAM, active-low, one cycle.
- `mem_wdata` out 8: write data, valid while `mem_lr_n`=0.
- `mem_rdata` in 8: RAM read data, registered by the RAM one cycle after `mem_ce_n`=0.
- `busy` out 1: high from the detected CS fall to the detected CS rise.
- `frame_err` out 1: sticky; cleared at the next detected CS fall.

## Operation
- Frame layout:
  - Byte 0 is the command. Bit 7: 1=write, 0=read. Bits 6:4 are ignored. Bits 3:0 are the start address.
  - Bytes 1..N are data bytes.
- States:
  - IDLE: entered on reset, on `ena`=0, or on detected CS rise.
  - CMD: entered on detected CS fall; shifts 8 bits.
  - WDATA / RDATA: selected by the command bit; each data byte is 8 bits.
- Sampling:
  - MOSI is shifted in on each detected SCLK rise.
  - The bit counter is 3 bits; it wraps 7→0 at the end of each byte.
- Write frames:
  - On the 8th rise of each data byte, the block drives `mem_wdata`=byte and `mem_addr`=current address, and pulses `mem_lr_n` low for exactly one cycle.
  - The address then increments, wrapping 0xF→0x0.
- Read frames:
  - On the 8th rise of the command byte, `mem_ce_n` pulses low for one cycle at the start address, with `mem_lr_n`=1.
  - `mem_rdata` is captured into a hold register two cycles after the pulse.
  - On the next detected SCLK fall, the hold register loads into the TX shift register, and `spi_miso`=TX[7].
  - Every later SCLK fall shifts TX left.
  - On the 8th rise of each data byte, the address increments with wrap, and the next read is issued as above.
- `mem_lr_n` and `mem_ce_n` are never low in the same cycle.
- CS rise mid-byte (bit counter ≠0):
  - Partial byte discarded, no strobe issued, `frame_err`=1.
  - Return to IDLE.
- CS rise after the command byte only: no error, no write.
- SCLK edges while CS is high are ignored.

## Timing
- Reset values: `spi_miso`=0, `spi_miso_oe`=0, `mem_addr`=0, `mem_ce_n`=1, `mem_lr_n`=1, `mem_wdata`=0, `busy`=0, `frame_err`=0. All internal state returns to IDLE with counters at 0.
- Edge-detect latency is SYNC_STAGES+1 cycles from the pin.
- SCLK high and low phases must each be ≥4 `clk` cycles. This guarantees read data is held before the first data-phase fall.
- The write strobe comes 1 cycle after the detected 8th rise; the read strobe likewise.
- `spi_miso` updates 1 cycle after the detected fall.
- `spi_miso_oe` rises with the first TX load and falls with the detected CS rise.
- Reset mid-frame aborts immediately. No strobe is issued in or after the reset cycle, and `frame_err` is not set.

## Structure
- Package `spi_mem_pkg`:
  - state enum (IDLE, CMD, WDATA, RDATA);
  - `CMD_WR_BIT`=7;
  - `CMD_ADDR_LSB`=0;
  - byte width 8.
- Sub-module `spi_edge_sync`: SYNC_STAGES-deep synchronizer plus registered rise/fall detect. Instantiated for `spi_cs_n` and `spi_sclk`; `spi_mosi` is synchronized only.
- The top-level holds the FSM, shift registers, address counter and strobe generation.

## Test plan
- Write frame 0x83, 0x5A → exactly one cycle with `mem_lr_n`=0, `mem_addr`=3, `mem_wdata`=0x5A, and `mem_ce_n`=1 throughout.
- Read frame 0x03, dummy 0x00 with the RAM model holding 0x5A at address 3 → one `mem_ce_n` pulse at address 3, and MISO returns 0x5A MSB first.
- Write burst 0x8E, 0x11, 0x22, 0x33 → writes land at addresses E, F, 0 (wrap) with values 0x11, 0x22, 0x33.
- Read burst from 0x0F over 3 data bytes with RAM[F]=0xA1, RAM[0]=0xB2, RAM[1]=0xC3 → MISO returns 0xA1, 0xB2, 0xC3.
- Write frame 0x85 then 5 data bits, then CS rise → no `mem_lr_n` pulse, `frame_err`=1; the next CS fall clears it.
- `rst_n`=0 asserted after bit 6 of a write data byte → next cycle all outputs at reset values. A following clean frame 0x81, 0x77 writes 0x77 to address 1.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI-to-RAM bridge: frame layout, byte width and FSM encodings.
package spi_mem_pkg;
  localparam int BYTE_W       = 8;
  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_LSB = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CMD   = 2'd1;
  localparam state_t ST_WDATA = 2'd2;
  localparam state_t ST_RDATA = 2'd3;
endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for an asynchronous pin with registered rise/fall pulses.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev   <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
      prev   <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev;
    end
  end
endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave that turns command/data frames into single-cycle RAM write/read strobes.
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_lr_n,
  output logic [BYTE_W-1:0] mem_wdata,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              frame_err
);
  logic cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi;

  // CS idles high, so its synchronizer resets high to avoid a phantom fall out of reset
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .din(spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(spi_mosi);
  end
  assign mosi = mosi_sync[SYNC_STAGES-1];

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-2:0] rx;
  logic [BYTE_W-1:0] rx_byte, tx, hold;
  logic              rd_vld;

  assign rx_byte  = {rx, mosi};
  assign spi_miso = tx[BYTE_W-1] & spi_miso_oe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx          <= '0;
      tx          <= '0;
      hold        <= '0;
      rd_vld      <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_addr    <= '0;
      mem_ce_n    <= 1'b1;
      mem_lr_n    <= 1'b1;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      mem_lr_n <= 1'b1;
      mem_ce_n <= 1'b1;
      // RAM output is valid the cycle after the read strobe
      rd_vld   <= ~mem_ce_n;
      if (rd_vld) hold <= mem_rdata;
      if (!mem_lr_n) mem_addr <= mem_addr + ADDR_W'(1);

      if (!ena) begin
        state       <= ST_IDLE;
        bit_cnt     <= '0;
        busy        <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (cs_fall) begin
        state       <= ST_CMD;
        bit_cnt     <= '0;
        busy        <= 1'b1;
        frame_err   <= 1'b0;
        tx          <= '0;
        spi_miso_oe <= 1'b0;
      end else if (cs_rise) begin
        if (state != ST_IDLE && bit_cnt != 3'd0) frame_err <= 1'b1;
        state       <= ST_IDLE;
        bit_cnt     <= '0;
        busy        <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (sclk_rise) begin
          rx      <= rx_byte[BYTE_W-2:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              ST_CMD: begin
                mem_addr <= rx_byte[CMD_ADDR_LSB +: ADDR_W];
                if (rx_byte[CMD_WR_BIT]) begin
                  state <= ST_WDATA;
                end else begin
                  state    <= ST_RDATA;
                  mem_ce_n <= 1'b0;
                end
              end
              ST_WDATA: begin
                mem_wdata <= rx_byte;
                mem_lr_n  <= 1'b0;
              end
              default: begin
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_ce_n <= 1'b0;
              end
            endcase
          end
        end else if (sclk_fall && state == ST_RDATA) begin
          // First fall of each data byte loads the prefetched byte; the rest shift
          if (bit_cnt == 3'd0) begin
            tx          <= hold;
            spi_miso_oe <= 1'b1;
          end else begin
            tx <= {tx[BYTE_W-2:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench: SPI master driving frames, behavioural 16-byte RAM, strobe log.
module tb_spi_mem_bridge;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n, ena, spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe, mem_ce_n, mem_lr_n, busy, frame_err;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  logic [7:0] ram [16];
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  logic [3:0] rd_addr_q [$];

  always #5 clk = ~clk;

  spi_mem_bridge #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_lr_n(mem_lr_n),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (!mem_lr_n) ram[mem_addr] <= mem_wdata;
      if (!mem_ce_n) mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (!mem_lr_n) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (!mem_ce_n) rd_addr_q.push_back(mem_addr);
    if (!mem_lr_n && !mem_ce_n) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = mo[i];
      wait_clk(HALF);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_miso"},  spi_miso,    1'b0);
    chk({pfx, "_oe"},    spi_miso_oe, 1'b0);
    chk({pfx, "_addr"},  mem_addr,    4'h0);
    chk({pfx, "_ce_n"},  mem_ce_n,    1'b1);
    chk({pfx, "_lr_n"},  mem_lr_n,    1'b1);
    chk({pfx, "_wdata"}, mem_wdata,   8'h00);
    chk({pfx, "_busy"},  busy,        1'b0);
    chk({pfx, "_err"},   frame_err,   1'b0);
  endtask

  initial begin
    logic [7:0] mi;
    int wb, rb;
    rst_n = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    wait_clk(4);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    wait_clk(4);

    // single write 0x83, 0x5A
    cs_low();
    chk("busy_in_frame", busy, 1'b1);
    spi_xfer(8'h83, 8, mi);
    spi_xfer(8'h5A, 8, mi);
    cs_high();
    chk("w1_count", wr_addr_q.size(), 1);
    chk("w1_addr", wr_addr_q[0], 4'h3);
    chk("w1_data", wr_data_q[0], 8'h5A);
    chk("w1_no_read", rd_addr_q.size(), 0);
    chk("busy_after", busy, 1'b0);
    chk("w1_err", frame_err, 1'b0);

    // single read 0x03 + dummy; second pulse is the prefetch of address 4
    cs_low();
    spi_xfer(8'h03, 8, mi);
    spi_xfer(8'h00, 8, mi);
    chk("r1_oe", spi_miso_oe, 1'b1);
    cs_high();
    chk("r1_miso", mi, 8'h5A);
    chk("r1_rd_count", rd_addr_q.size(), 2);
    chk("r1_rd_addr", rd_addr_q[0], 4'h3);
    chk("r1_prefetch", rd_addr_q[1], 4'h4);
    chk("r1_no_write", wr_addr_q.size(), 1);
    chk("r1_oe_off", spi_miso_oe, 1'b0);

    // write burst with address wrap
    wb = wr_addr_q.size();
    cs_low();
    spi_xfer(8'h8E, 8, mi);
    spi_xfer(8'h11, 8, mi);
    spi_xfer(8'h22, 8, mi);
    spi_xfer(8'h33, 8, mi);
    cs_high();
    chk("wb_count", wr_addr_q.size() - wb, 3);
    chk("wb_a0", wr_addr_q[wb],   4'hE);
    chk("wb_d0", wr_data_q[wb],   8'h11);
    chk("wb_a1", wr_addr_q[wb+1], 4'hF);
    chk("wb_d1", wr_data_q[wb+1], 8'h22);
    chk("wb_a2", wr_addr_q[wb+2], 4'h0);
    chk("wb_d2", wr_data_q[wb+2], 8'h33);

    // load F,0,1 then read burst from F
    cs_low();
    spi_xfer(8'h8F, 8, mi);
    spi_xfer(8'hA1, 8, mi);
    spi_xfer(8'hB2, 8, mi);
    spi_xfer(8'hC3, 8, mi);
    cs_high();
    rb = rd_addr_q.size();
    cs_low();
    spi_xfer(8'h0F, 8, mi);
    spi_xfer(8'h00, 8, mi);
    chk("rb_b0", mi, 8'hA1);
    spi_xfer(8'h00, 8, mi);
    chk("rb_b1", mi, 8'hB2);
    spi_xfer(8'h00, 8, mi);
    chk("rb_b2", mi, 8'hC3);
    cs_high();
    chk("rb_first_addr", rd_addr_q[rb], 4'hF);
    chk("rb_wrap_addr", rd_addr_q[rb+1], 4'h0);

    // CS rise mid-byte
    wb = wr_addr_q.size();
    cs_low();
    spi_xfer(8'h85, 8, mi);
    spi_xfer(8'hFF, 5, mi);
    cs_high();
    chk("abort_no_write", wr_addr_q.size() - wb, 0);
    chk("abort_err", frame_err, 1'b1);
    cs_low();
    chk("abort_err_clr", frame_err, 1'b0);
    cs_high();

    // CS rise right after command byte: no error
    cs_low();
    spi_xfer(8'h82, 8, mi);
    cs_high();
    chk("cmd_only_err", frame_err, 1'b0);
    chk("cmd_only_no_write", wr_addr_q.size() - wb, 0);

    // ena low mid-frame
    cs_low();
    ena = 1'b0;
    wait_clk(2);
    chk("ena_busy", busy, 1'b0);
    ena = 1'b1;
    cs_high();

    // reset after 7 bits of a write data byte
    cs_low();
    spi_xfer(8'h84, 8, mi);
    spi_xfer(8'h99, 7, mi);
    rst_n = 1'b0;
    wait_clk(1);
    chk_reset_outputs("midrst");
    rst_n = 1'b1;
    wb = wr_addr_q.size();
    cs_high();
    chk("midrst_err", frame_err, 1'b0);
    cs_low();
    spi_xfer(8'h81, 8, mi);
    spi_xfer(8'h77, 8, mi);
    cs_high();
    chk("post_rst_count", wr_addr_q.size() - wb, 1);
    chk("post_rst_addr", wr_addr_q[wb], 4'h1);
    chk("post_rst_ram", ram[1], 8'h77);
    chk("no_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
